// File: rtl/eth_tx_pkt_arbiter.sv
// eth_tx_pkt_arbiter
// Packet-level round-robin arbiter merging NUM_IN 512-bit Avalon-ST sources
// onto one Ethernet TX stream. A source owns the output from its sop beat
// until its eop beat is accepted. One registered output stage, a packet
// counter and a protocol-drop counter.

module eth_tx_pkt_arbiter #(
  parameter int NUM_IN = 2,
  parameter int IDX_W  = $clog2(NUM_IN)
) (
  input  logic                    Clk,
  input  logic                    Rst,

  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [NUM_IN*512-1:0]   in_data,
  input  logic [NUM_IN-1:0]       in_sop,
  input  logic [NUM_IN-1:0]       in_eop,
  input  logic [NUM_IN*6-1:0]     in_empty,

  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [511:0]            out_data,
  output logic                    out_sop,
  output logic                    out_eop,
  output logic [5:0]              out_empty,
  input  logic                    out_almost_full,

  output logic [31:0]             pkt_cnt,
  output logic [31:0]             drop_cnt,
  output logic [IDX_W-1:0]        grant_idx
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,  // waiting for a sop candidate
    ST_LOCK = 1'b1   // a packet is in flight from grant_idx
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [IDX_W-1:0]  rr_ptr;

  logic              adv;        // output register can take a beat this cycle
  logic [NUM_IN-1:0] cand;       // sources offering a sop beat
  logic [IDX_W-1:0]  win;        // round-robin winner among cand
  logic              win_found;
  logic [NUM_IN-1:0] drop_mask;  // non-sop beats discarded while idle
  logic [2:0]        drop_num;
  logic              accept;     // a beat moves into the output register
  logic [IDX_W-1:0]  sel;        // source whose beat is accepted

  logic [511:0]      sel_data;
  logic              sel_sop;
  logic              sel_eop;
  logic [5:0]        sel_empty;

  // Successor of a source index, wrapping at NUM_IN (which need not be a
  // power of two).
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0] nxt;
    if (int'(idx) >= NUM_IN - 1) nxt = '0;
    else                         nxt = idx + IDX_W'(1);
    return nxt;
  endfunction

  assign adv  = !out_valid || out_ready;
  assign cand = in_valid & in_sop;

  // Round-robin search over sop candidates, starting at rr_ptr.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    win       = '0;
    win_found = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (!win_found && cand[(int'(rr_ptr) + k) % NUM_IN]) begin
        win_found = 1'b1;
        win       = IDX_W'((int'(rr_ptr) + k) % NUM_IN);
      end
    end
  end

  // Handshake outputs: who is ready, whether a beat is accepted, and from where.
  // Ready is held low while Rst is asserted so no source sees a handshake
  // that the reset registers will not record.
  always_comb begin
    in_ready  = '0;
    drop_mask = '0;
    accept    = 1'b0;
    sel       = grant_idx;
    if (!Rst) begin
      unique case (state)
        ST_IDLE: begin
          // Mid-packet beats with no owner are discarded regardless of
          // backpressure or almost_full.
          drop_mask = in_valid & ~in_sop;
          in_ready  = drop_mask;
          sel       = win;
          accept    = adv && !out_almost_full && win_found;
          if (accept) in_ready[win] = 1'b1;
        end
        ST_LOCK: begin
          // almost_full only blocks packet starts, never a packet in flight.
          in_ready[grant_idx] = adv;
          accept              = adv && in_valid[grant_idx];
        end
        default: ;
      endcase
    end
  end

  // Number of beats dropped this cycle.
  always_comb begin
    drop_num = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      drop_num = drop_num + 3'(drop_mask[i]);
    end
  end

  // Beat mux from the selected source.
  always_comb begin
    sel_data  = in_data[int'(sel)*512 +: 512];
    sel_sop   = in_sop[sel];
    sel_eop   = in_eop[sel];
    sel_empty = in_empty[int'(sel)*6 +: 6];
  end

  // Next-state: lock on a multi-beat packet start, unlock when its eop is taken.
  // A sop seen while locked is just another beat of the same packet.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (accept && !sel_eop) state_nxt = ST_LOCK;
      ST_LOCK: if (accept &&  sel_eop) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clk or posedge Rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (Rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Grant bookkeeping: record the winner on a packet start and move the
  // round-robin pointer past the source whose eop was just accepted.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      grant_idx <= '0;
      rr_ptr    <= '0;
    end else begin
      if (state == ST_IDLE && accept) grant_idx <= win;
      if (accept && sel_eop)          rr_ptr    <= next_idx(sel);
    end
  end

  // Output register: load on accept, otherwise drain when downstream takes it.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_empty <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_sop   <= sel_sop;
      out_eop   <= sel_eop;
      out_empty <= sel_empty;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Status counters; both wrap naturally at 2^32.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (out_valid && out_ready && out_eop) pkt_cnt <= pkt_cnt + 32'd1;
      drop_cnt <= drop_cnt + 32'(drop_num);
    end
  end

endmodule

// File: tb/tb_eth_tx_pkt_arbiter.sv
// tb_eth_tx_pkt_arbiter
// Directed scenarios for the packet arbiter. Each source is a small beat
// generator that advances whenever its beat is handshaken; the output stream
// is captured and compared against hand-derived beat lists.

module tb_eth_tx_pkt_arbiter;

  localparam int NUM_IN = 2;
  localparam int IDX_W  = 1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_IN-1:0]     in_valid;
  logic [NUM_IN-1:0]     in_ready;
  logic [NUM_IN*512-1:0] in_data;
  logic [NUM_IN-1:0]     in_sop;
  logic [NUM_IN-1:0]     in_eop;
  logic [NUM_IN*6-1:0]   in_empty;
  logic                  out_valid;
  logic                  out_ready;
  logic [511:0]          out_data;
  logic                  out_sop;
  logic                  out_eop;
  logic [5:0]            out_empty;
  logic                  out_almost_full;
  logic [31:0]           pkt_cnt;
  logic [31:0]           drop_cnt;
  logic [IDX_W-1:0]      grant_idx;

  eth_tx_pkt_arbiter #(.NUM_IN(NUM_IN)) dut (
    .Clk             (clk),
    .Rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .in_sop          (in_sop),
    .in_eop          (in_eop),
    .in_empty        (in_empty),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_sop         (out_sop),
    .out_eop         (out_eop),
    .out_empty       (out_empty),
    .out_almost_full (out_almost_full),
    .pkt_cnt         (pkt_cnt),
    .drop_cnt        (drop_cnt),
    .grant_idx       (grant_idx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Source generator state.
  int  s_npkt [NUM_IN];
  int  s_len  [NUM_IN];
  int  s_start[NUM_IN];
  bit  s_nosop[NUM_IN];
  int  s_pkt  [NUM_IN];
  int  s_beat [NUM_IN];
  logic [31:0] ready_pat;
  logic [31:0] af_pat;

  // Per-cycle observations of the last run.
  logic [NUM_IN-1:0] rdy_hist[64];
  bit                ov_hist [64];
  logic [15:0]       tag_hist[64];

  // Captured output beats: {empty[5:0], sop, eop, data[511:0]}.
  logic [519:0] cap[$];
  logic [519:0] exp_q[$];

  function automatic logic [15:0] mk_tag(input int s, input int p, input int b);
    return {s[3:0], p[3:0], b[7:0]};
  endfunction

  function automatic logic [519:0] exp_beat(input int s, input int p, input int b, input int len);
    logic [15:0] tag;
    logic        e;
    tag = mk_tag(s, p, b);
    e   = (b == len - 1);
    return {(e ? 6'(5 + s) : 6'd0), (b == 0), e, {32{tag}}};
  endfunction

  task automatic init_sources();
    for (int i = 0; i < NUM_IN; i++) begin
      s_npkt[i] = 0; s_len[i] = 1; s_start[i] = 0; s_nosop[i] = 1'b0;
      s_pkt[i]  = 0; s_beat[i] = 0;
    end
    ready_pat = 32'hFFFF_FFFF;
    af_pat    = 32'h0;
  endtask

  task automatic drive_sources(input int c);
    for (int i = 0; i < NUM_IN; i++) begin
      bit          act;
      logic [15:0] tag;
      bit          last;
      act  = (c >= s_start[i]) && (s_pkt[i] < s_npkt[i]);
      tag  = mk_tag(i, s_pkt[i], s_beat[i]);
      last = (s_beat[i] == s_len[i] - 1);
      in_valid[i] = act;
      in_sop[i]   = act && (s_beat[i] == 0) && !s_nosop[i];
      in_eop[i]   = act && last;
      in_data[i*512 +: 512] = act ? {32{tag}} : '0;
      in_empty[i*6 +: 6]    = (act && last) ? 6'(5 + i) : 6'd0;
    end
    out_ready       = (c < 32) ? ready_pat[c] : 1'b1;
    out_almost_full = (c < 32) ? af_pat[c]    : 1'b0;
  endtask

  task automatic idle_inputs();
    in_valid = '0; in_sop = '0; in_eop = '0; in_data = '0; in_empty = '0;
    out_ready = 1'b0; out_almost_full = 1'b0;
  endtask

  // Runs ncyc cycles: drive at edge+1, sample at edge+2, advance sources on
  // the handshakes seen before the edge.
  task automatic run_traffic(input int ncyc);
    cap.delete();
    for (int c = 0; c < ncyc; c++) begin
      logic [NUM_IN-1:0] acc;
      drive_sources(c);
      #1;
      rdy_hist[c] = in_ready;
      ov_hist[c]  = out_valid;
      tag_hist[c] = out_data[15:0];
      if (out_valid && out_ready) cap.push_back({out_empty, out_sop, out_eop, out_data});
      acc = in_valid & in_ready;
      @(posedge clk); #1;
      for (int i = 0; i < NUM_IN; i++) begin
        if (acc[i]) begin
          s_beat[i]++;
          if (s_beat[i] == s_len[i]) begin
            s_beat[i] = 0;
            s_pkt[i]++;
          end
        end
      end
    end
    idle_inputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    in_valid = 2'b11; in_sop = 2'b11; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_data !== '0) $display("FAIL reset_out_data got %h want 0", out_data[15:0]); else n_pass++;
    n_checks++; if ({out_sop, out_eop} !== 2'b00) $display("FAIL reset_sop_eop got %b want 00", {out_sop, out_eop}); else n_pass++;
    n_checks++; if (in_ready !== 2'b00) $display("FAIL reset_in_ready got %b want 00", in_ready); else n_pass++;
    n_checks++; if (pkt_cnt !== 32'd0 || drop_cnt !== 32'd0) $display("FAIL reset_counters got %0d/%0d want 0/0", pkt_cnt, drop_cnt); else n_pass++;
    n_checks++; if (grant_idx !== 1'b0) $display("FAIL reset_grant_idx got %0d want 0", grant_idx); else n_pass++;
    idle_inputs();
    rst = 1'b0;
  endtask

  task automatic test_round_robin();
    bit gap;
    do_reset(); init_sources();
    s_npkt[0] = 2; s_npkt[1] = 2; s_len[0] = 3; s_len[1] = 3;
    run_traffic(14);
    exp_q.delete();
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < 2; s++)
        for (int b = 0; b < 3; b++) exp_q.push_back(exp_beat(s, p, b, 3));
    n_checks++; if (cap.size() != exp_q.size()) $display("FAIL rr_beat_count got %0d want %0d", cap.size(), exp_q.size()); else n_pass++;
    for (int k = 0; k < exp_q.size(); k++) begin
      n_checks++;
      if (k >= cap.size() || cap[k] !== exp_q[k])
        $display("FAIL rr_beat %0d got tag=%h flags=%b want tag=%h flags=%b", k,
                 (k < cap.size()) ? cap[k][15:0] : 16'hxxxx, (k < cap.size()) ? cap[k][519:512] : 8'hxx,
                 exp_q[k][15:0], exp_q[k][519:512]);
      else n_pass++;
    end
    gap = 1'b0;
    for (int c = 1; c <= 12; c++) if (!ov_hist[c]) gap = 1'b1;
    n_checks++; if (gap !== 1'b0 || ov_hist[0] !== 1'b0) $display("FAIL rr_contiguous got gap=%b first=%b want 0/0", gap, ov_hist[0]); else n_pass++;
    n_checks++; if (pkt_cnt !== 32'd4) $display("FAIL rr_pkt_cnt got %0d want 4", pkt_cnt); else n_pass++;
    n_checks++; if (grant_idx !== 1'b1) $display("FAIL rr_grant_idx got %0d want 1", grant_idx); else n_pass++;
  endtask

  task automatic test_no_interleave();
    do_reset(); init_sources();
    s_npkt[0] = 1; s_len[0] = 5; s_start[0] = 0;
    s_npkt[1] = 1; s_len[1] = 3; s_start[1] = 2;
    run_traffic(10);
    exp_q.delete();
    for (int b = 0; b < 5; b++) exp_q.push_back(exp_beat(0, 0, b, 5));
    for (int b = 0; b < 3; b++) exp_q.push_back(exp_beat(1, 0, b, 3));
    n_checks++; if (cap.size() != exp_q.size()) $display("FAIL noint_beat_count got %0d want %0d", cap.size(), exp_q.size()); else n_pass++;
    for (int k = 0; k < exp_q.size(); k++) begin
      n_checks++;
      if (k >= cap.size() || cap[k] !== exp_q[k])
        $display("FAIL noint_beat %0d got tag=%h want tag=%h", k,
                 (k < cap.size()) ? cap[k][15:0] : 16'hxxxx, exp_q[k][15:0]);
      else n_pass++;
    end
    n_checks++;
    if ({rdy_hist[2][1], rdy_hist[3][1], rdy_hist[4][1]} !== 3'b000)
      $display("FAIL noint_ready1_locked got %b want 000", {rdy_hist[2][1], rdy_hist[3][1], rdy_hist[4][1]});
    else n_pass++;
    n_checks++; if (rdy_hist[5][1] !== 1'b1) $display("FAIL noint_ready1_after_eop got %b want 1", rdy_hist[5][1]); else n_pass++;
  endtask

  task automatic test_backpressure();
    do_reset(); init_sources();
    s_npkt[0] = 1; s_len[0] = 4;
    ready_pat = 32'hFFFF_FFF3;  // out_ready: c0..c3 = 1,1,0,0 then 1
    run_traffic(9);
    exp_q.delete();
    for (int b = 0; b < 4; b++) exp_q.push_back(exp_beat(0, 0, b, 4));
    n_checks++; if (cap.size() != exp_q.size()) $display("FAIL bp_beat_count got %0d want %0d", cap.size(), exp_q.size()); else n_pass++;
    for (int k = 0; k < exp_q.size(); k++) begin
      n_checks++;
      if (k >= cap.size() || cap[k] !== exp_q[k])
        $display("FAIL bp_beat %0d got tag=%h want tag=%h", k,
                 (k < cap.size()) ? cap[k][15:0] : 16'hxxxx, exp_q[k][15:0]);
      else n_pass++;
    end
    n_checks++;
    if (!ov_hist[2] || !ov_hist[3] || tag_hist[2] !== mk_tag(0, 0, 1) || tag_hist[3] !== mk_tag(0, 0, 1))
      $display("FAIL bp_hold got %h/%h valid %b%b want %h held", tag_hist[2], tag_hist[3], ov_hist[2], ov_hist[3], mk_tag(0, 0, 1));
    else n_pass++;
    n_checks++; if ({rdy_hist[2][0], rdy_hist[3][0]} !== 2'b00) $display("FAIL bp_ready_stalled got %b want 00", {rdy_hist[2][0], rdy_hist[3][0]}); else n_pass++;
    n_checks++;
    if (!ov_hist[5] || tag_hist[5] !== mk_tag(0, 0, 2))
      $display("FAIL bp_latency got %h valid %b want %h", tag_hist[5], ov_hist[5], mk_tag(0, 0, 2));
    else n_pass++;
    n_checks++; if (ov_hist[7] !== 1'b0) $display("FAIL bp_drain got %b want 0", ov_hist[7]); else n_pass++;
    n_checks++; if (pkt_cnt !== 32'd1) $display("FAIL bp_pkt_cnt got %0d want 1", pkt_cnt); else n_pass++;
  endtask

  task automatic test_almost_full();
    bit any_v;
    bit any_r;
    do_reset(); init_sources();
    s_npkt[0] = 1; s_len[0] = 3;
    af_pat = 32'h0000_006F;  // high c0..c3, low c4, high c5..c6
    run_traffic(9);
    any_v = 1'b0; any_r = 1'b0;
    for (int c = 0; c <= 4; c++) any_v |= ov_hist[c];
    for (int c = 0; c <= 3; c++) any_r |= rdy_hist[c][0];
    n_checks++; if (any_v !== 1'b0) $display("FAIL af_no_output got %b want 0", any_v); else n_pass++;
    n_checks++; if (any_r !== 1'b0) $display("FAIL af_no_grant got %b want 0", any_r); else n_pass++;
    exp_q.delete();
    for (int b = 0; b < 3; b++) exp_q.push_back(exp_beat(0, 0, b, 3));
    n_checks++; if (cap.size() != exp_q.size()) $display("FAIL af_beat_count got %0d want %0d", cap.size(), exp_q.size()); else n_pass++;
    for (int k = 0; k < exp_q.size(); k++) begin
      n_checks++;
      if (k >= cap.size() || cap[k] !== exp_q[k])
        $display("FAIL af_beat %0d got tag=%h want tag=%h", k,
                 (k < cap.size()) ? cap[k][15:0] : 16'hxxxx, exp_q[k][15:0]);
      else n_pass++;
    end
    n_checks++;
    if ({ov_hist[5], ov_hist[6], ov_hist[7]} !== 3'b111)
      $display("FAIL af_mid_packet got %b want 111", {ov_hist[5], ov_hist[6], ov_hist[7]});
    else n_pass++;
  endtask

  task automatic test_protocol_drop();
    bit any_v;
    do_reset(); init_sources();
    s_npkt[1] = 1; s_len[1] = 2; s_nosop[1] = 1'b1;
    af_pat = 32'hFFFF_FFFF;
    run_traffic(4);
    any_v = 1'b0;
    for (int c = 0; c < 4; c++) any_v |= ov_hist[c];
    n_checks++; if ({rdy_hist[0][1], rdy_hist[1][1]} !== 2'b11) $display("FAIL drop_ready got %b want 11", {rdy_hist[0][1], rdy_hist[1][1]}); else n_pass++;
    n_checks++; if (drop_cnt !== 32'd2) $display("FAIL drop_cnt got %0d want 2", drop_cnt); else n_pass++;
    n_checks++; if (any_v !== 1'b0 || cap.size() != 0) $display("FAIL drop_no_output got valid=%b beats=%0d want 0/0", any_v, cap.size()); else n_pass++;
    n_checks++; if (pkt_cnt !== 32'd0) $display("FAIL drop_pkt_cnt got %0d want 0", pkt_cnt); else n_pass++;
  endtask

  task automatic test_multi_drop();
    do_reset(); init_sources();
    s_npkt[0] = 1; s_len[0] = 1; s_nosop[0] = 1'b1;
    s_npkt[1] = 1; s_len[1] = 1; s_nosop[1] = 1'b1;
    run_traffic(1);
    n_checks++; if (rdy_hist[0] !== 2'b11) $display("FAIL mdrop_ready got %b want 11", rdy_hist[0]); else n_pass++;
    n_checks++; if (drop_cnt !== 32'd2) $display("FAIL mdrop_cnt got %0d want 2", drop_cnt); else n_pass++;
  endtask

  task automatic test_reset_mid_packet();
    do_reset(); init_sources();
    s_npkt[0] = 2; s_len[0] = 4;
    run_traffic(2);
    // Source 0 now holds beat 2 of 4; reset hits while it is offered.
    drive_sources(0);
    rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rmid_out_valid got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_data !== '0 || out_empty !== 6'd0) $display("FAIL rmid_out_data got %h/%0d want 0/0", out_data[15:0], out_empty); else n_pass++;
    n_checks++; if ({out_sop, out_eop} !== 2'b00) $display("FAIL rmid_sop_eop got %b want 00", {out_sop, out_eop}); else n_pass++;
    n_checks++; if (in_ready !== 2'b00) $display("FAIL rmid_in_ready got %b want 00", in_ready); else n_pass++;
    n_checks++; if (grant_idx !== 1'b0) $display("FAIL rmid_grant_idx got %0d want 0", grant_idx); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    run_traffic(10);
    n_checks++; if (drop_cnt !== 32'd2) $display("FAIL rmid_drop_cnt got %0d want 2", drop_cnt); else n_pass++;
    exp_q.delete();
    for (int b = 0; b < 4; b++) exp_q.push_back(exp_beat(0, 1, b, 4));
    n_checks++; if (cap.size() != exp_q.size()) $display("FAIL rmid_beat_count got %0d want %0d", cap.size(), exp_q.size()); else n_pass++;
    for (int k = 0; k < exp_q.size(); k++) begin
      n_checks++;
      if (k >= cap.size() || cap[k] !== exp_q[k])
        $display("FAIL rmid_beat %0d got tag=%h want tag=%h", k,
                 (k < cap.size()) ? cap[k][15:0] : 16'hxxxx, exp_q[k][15:0]);
      else n_pass++;
    end
    n_checks++; if (pkt_cnt !== 32'd1) $display("FAIL rmid_pkt_cnt got %0d want 1", pkt_cnt); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_no_interleave();
    test_backpressure();
    test_almost_full();
    test_protocol_drop();
    test_multi_drop();
    test_reset_mid_packet();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
